// File: rtl/ai_traffic_scheduler_pkg.sv
// Shared car-state layout used by the scheduler and the single-car controllers.
package ai_traffic_scheduler_pkg;

    localparam int unsigned CAR_FIELDS = 5;
    localparam int unsigned FIELD_W    = 11;

    // Field positions inside car_state_t, MSB first: {img_id, x, y, width, height}
    localparam int unsigned IDX_IMG = 4;
    localparam int unsigned IDX_X   = 3;
    localparam int unsigned IDX_Y   = 2;
    localparam int unsigned IDX_W   = 1;
    localparam int unsigned IDX_H   = 0;

    localparam logic [FIELD_W-1:0] CAR_SIZE = 11'd64;

    typedef logic [CAR_FIELDS-1:0][FIELD_W-1:0] car_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_SPAWN,
        S_PUBLISH
    } sched_state_t;

    function automatic car_state_t make_car(input logic [FIELD_W-1:0] img,
                                            input logic [FIELD_W-1:0] x,
                                            input logic [FIELD_W-1:0] y);
        car_state_t c;
        c          = '0;
        c[IDX_IMG] = img;
        c[IDX_X]   = x;
        c[IDX_Y]   = y;
        c[IDX_W]   = CAR_SIZE;
        c[IDX_H]   = CAR_SIZE;
        return c;
    endfunction

    localparam car_state_t CAR_DEFAULT = make_car(11'd1, 11'd0, 11'd0);

endpackage

// File: rtl/ai_traffic_scheduler_if.sv
// Frame-side inputs and published snapshot outputs of the traffic scheduler.
interface ai_traffic_scheduler_if
    import ai_traffic_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CARS = 4
);

    logic                        frame_start;
    logic [10:0]                 random;
    logic [3:0]                  speed;
    car_state_t [NUM_CARS-1:0]   cars_state;
    logic [NUM_CARS-1:0]         active;
    logic                        spawn_pulse;
    logic                        overrun;

    modport master (
        output frame_start, random, speed,
        input  cars_state, active, spawn_pulse, overrun
    );

    modport slave (
        input  frame_start, random, speed,
        output cars_state, active, spawn_pulse, overrun
    );

endinterface

// File: rtl/ai_traffic_scheduler_slot_finder.sv
// Priority encoder: lowest-index slot whose active bit is clear.
module slot_finder #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  active_mask,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && !active_mask[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/ai_traffic_scheduler.sv
// Per-frame AI car scheduler: move each slot, maybe spawn one car, then publish
// a consistent snapshot of all slots.
module ai_traffic_scheduler
    import ai_traffic_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CARS  = 4,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned X_MIN     = 192,
    parameter int unsigned X_SPAN    = 128,
    parameter int unsigned SPAWN_GAP = 60
) (
    input  logic clk,
    input  logic resetN,
    ai_traffic_scheduler_if.slave bus
);

    localparam int unsigned IW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int unsigned CW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

    localparam logic [11:0]   Y_LIMIT  = 12'(SCREEN_H);
    localparam logic [10:0]   X_BASE   = 11'(X_MIN);
    localparam logic [10:0]   X_MASK   = 11'(X_SPAN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CARS - 1);
    localparam logic [CW-1:0] GAP      = CW'(SPAWN_GAP);

    sched_state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic move_en, spawn_en, pub_en;

    car_state_t [NUM_CARS-1:0] cars_w, cars_pub;
    logic [NUM_CARS-1:0]       active_w, active_pub;
    logic [CW-1:0]             cooldown;
    logic                      spawn_pulse_q;
    logic                      overrun_q;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic [11:0]   y_next;
    logic [10:0]   spawn_img;
    logic [10:0]   spawn_x;

    slot_finder #(
        .N  (NUM_CARS),
        .IW (IW)
    ) u_slot_finder (
        .active_mask (active_w),
        .found       (free_found),
        .idx         (free_idx)
    );

    // One bit of headroom so the off-screen test cannot wrap.
    assign y_next    = {1'b0, cars_w[idx][IDX_Y]} + {8'd0, bus.speed};
    assign spawn_img = {9'd0, bus.random[10:9]} + 11'd1;
    assign spawn_x   = X_BASE + (bus.random & X_MASK);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        move_en  = 1'b0;
        spawn_en = 1'b0;
        pub_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_n = S_MOVE;
                    idx_n   = '0;
                end
            end
            S_MOVE: begin
                move_en = 1'b1;
                if (idx == LAST_IDX) state_n = S_SPAWN;
                else                 idx_n   = idx + IW'(1);
            end
            S_SPAWN: begin
                spawn_en = 1'b1;
                state_n  = S_PUBLISH;
            end
            S_PUBLISH: begin
                pub_en  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cars_w        <= {NUM_CARS{CAR_DEFAULT}};
            active_w      <= '0;
            cars_pub      <= {NUM_CARS{CAR_DEFAULT}};
            active_pub    <= '0;
            cooldown      <= '0;
            spawn_pulse_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            spawn_pulse_q <= 1'b0;
            if (bus.frame_start && state != S_IDLE) overrun_q <= 1'b1;

            if (move_en && active_w[idx]) begin
                if (y_next >= Y_LIMIT) active_w[idx] <= 1'b0;
                else                   cars_w[idx][IDX_Y] <= y_next[10:0];
            end

            // A full screen with cooldown at zero simply leaves cooldown at zero.
            if (spawn_en) begin
                if (cooldown == '0 && free_found) begin
                    cars_w[free_idx]   <= make_car(spawn_img, spawn_x, 11'd0);
                    active_w[free_idx] <= 1'b1;
                    cooldown           <= GAP;
                    spawn_pulse_q      <= 1'b1;
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - CW'(1);
                end
            end

            if (pub_en) begin
                cars_pub   <= cars_w;
                active_pub <= active_w;
            end
        end
    end

    assign bus.cars_state  = cars_pub;
    assign bus.active      = active_pub;
    assign bus.spawn_pulse = spawn_pulse_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_ai_traffic_scheduler.sv
// Randomized bench for ai_traffic_scheduler against a frame-level model of car slots.
module tb_ai_traffic_scheduler;
    import ai_traffic_scheduler_pkg::*;

    localparam int NC    = 4;
    localparam int SH    = 480;
    localparam int XMIN  = 192;
    localparam int XSPAN = 128;
    localparam int GAP   = 60;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    ai_traffic_scheduler_if #(.NUM_CARS(NC)) bus();

    ai_traffic_scheduler #(
        .NUM_CARS  (NC),
        .SCREEN_H  (SH),
        .X_MIN     (XMIN),
        .X_SPAN    (XSPAN),
        .SPAWN_GAP (GAP)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int tests  = 0;
    int failed = 0;

    // Model: per-slot state as plain integers, updated once per accepted frame
    int m_img [NC];
    int m_x   [NC];
    int m_y   [NC];
    bit m_act [NC];
    int m_cd;

    car_state_t [NC-1:0] e_cars;
    logic [NC-1:0]       e_active;
    logic                e_pulse;
    logic                e_overrun;
    bit                  chk_en = 1'b0;
    int                  frame_pulses = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_img[i] = 1; m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0;
        end
        m_cd = 0;
    endfunction

    function automatic void model_publish();
        for (int i = 0; i < NC; i++) begin
            e_cars[i]   = {11'(m_img[i]), 11'(m_x[i]), 11'(m_y[i]), 11'd64, 11'd64};
            e_active[i] = m_act[i];
        end
    endfunction

    function automatic bit model_frame(input int rnd, input int spd);
        int slot = -1;
        for (int i = 0; i < NC; i++)
            if (m_act[i]) begin
                if (m_y[i] + spd >= SH) m_act[i] = 1'b0;
                else                    m_y[i]   = m_y[i] + spd;
            end
        for (int i = NC - 1; i >= 0; i--)
            if (!m_act[i]) slot = i;
        if (m_cd == 0 && slot >= 0) begin
            m_img[slot] = 1 + rnd / 512;
            m_x[slot]   = XMIN + rnd % XSPAN;
            m_y[slot]   = 0;
            m_act[slot] = 1'b1;
            m_cd        = GAP;
            return 1'b1;
        end
        if (m_cd > 0) m_cd--;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NC; i++)
                check($sformatf("cars_state[%0d]", i), 64'(bus.cars_state[i]), 64'(e_cars[i]));
            check("active", 64'(bus.active), 64'(e_active));
            check("spawn_pulse", 64'(bus.spawn_pulse), 64'(e_pulse));
            check("overrun", 64'(bus.overrun), 64'(e_overrun));
            if (bus.spawn_pulse === 1'b1) frame_pulses++;
        end
    end

    // mode: 0 plain, 1 extra frame_start during MOVE, 2 extra frame_start in
    // the PUBLISH cycle, 3 reset asserted mid-MOVE (frame aborted)
    task automatic run_frame(input logic [10:0] rnd, input logic [3:0] spd, input int mode);
        bit sp;
        @(negedge clk);
        frame_pulses    = 0;
        bus.frame_start = 1'b1;
        bus.random      = rnd;
        bus.speed       = spd;
        sp = model_frame(int'(rnd), int'(spd));
        for (int e = 0; e <= 6; e++) begin
            @(posedge clk); #1;
            case (e)
                0: bus.frame_start = 1'b0;
                1: if (mode == 1) bus.frame_start = 1'b1;
                2: begin
                    if (mode == 1) begin
                        bus.frame_start = 1'b0;
                        e_overrun       = 1'b1;
                    end else if (mode == 3) begin
                        resetN = 1'b0;
                        model_reset();
                        model_publish();
                        e_pulse   = 1'b0;
                        e_overrun = 1'b0;
                        return;
                    end
                end
                5: begin
                    e_pulse = sp;
                    if (mode == 2) bus.frame_start = 1'b1;
                end
                6: begin
                    e_pulse = 1'b0;
                    model_publish();
                    if (mode == 2) begin
                        bus.frame_start = 1'b0;
                        e_overrun       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        resetN          = 1'b0;
        bus.frame_start = 1'b0;
        bus.random      = '0;
        bus.speed       = '0;
        model_reset();
        model_publish();
        e_pulse   = 1'b0;
        e_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("reset active", 64'(bus.active), 64'd0);
        check("reset slot0", 64'(bus.cars_state[0]), 64'({11'd1, 11'd0, 11'd0, 11'd64, 11'd64}));
        check("reset slot3", 64'(bus.cars_state[3]), 64'({11'd1, 11'd0, 11'd0, 11'd64, 11'd64}));
        check("reset overrun", 64'(bus.overrun), 64'd0);
        @(posedge clk); #1 resetN = 1'b1;

        // First frame: spawn into slot 0 from random 0x005
        run_frame(11'h005, 4'd0, 0);
        check("first spawn slot0", 64'(bus.cars_state[0]), 64'({11'd1, 11'd197, 11'd0, 11'd64, 11'd64}));
        check("first spawn active", 64'(bus.active), 64'h1);
        check("first spawn pulses", 64'(frame_pulses), 64'd1);

        // Frames 2..120 at speed 4: slot0 climbs to 476, slot1 spawns at frame 62
        for (int f = 2; f <= 120; f++) run_frame(11'($urandom), 4'd4, 0);
        check("slot0 y at 476", 64'(bus.cars_state[0][IDX_Y]), 64'd476);
        check("slot0 still active", 64'(bus.active[0]), 64'd1);
        run_frame(11'($urandom), 4'd4, 0);
        check("slot0 left screen", 64'(bus.active[0]), 64'd0);
        check("slot0 keeps old y", 64'(bus.cars_state[0][IDX_Y]), 64'd476);
        run_frame(11'($urandom), 4'd4, 0);
        check("cooldown holds frame 122", 64'(frame_pulses), 64'd0);
        run_frame(11'($urandom), 4'd4, 0);
        check("spawn at frame 123", 64'(frame_pulses), 64'd1);
        check("respawn lowest slot", 64'(bus.active), 64'h3);
        check("respawn y", 64'(bus.cars_state[0][IDX_Y]), 64'd0);

        run_frame(11'($urandom), 4'd4, 1);
        check("overrun during MOVE", 64'(bus.overrun), 64'd1);
        run_frame(11'($urandom), 4'd4, 2);
        check("overrun sticky", 64'(bus.overrun), 64'd1);

        run_frame(11'($urandom), 4'd4, 3);
        @(negedge clk);
        check("midframe reset active", 64'(bus.active), 64'd0);
        check("midframe reset overrun", 64'(bus.overrun), 64'd0);
        check("midframe reset slot1", 64'(bus.cars_state[1]), 64'({11'd1, 11'd0, 11'd0, 11'd64, 11'd64}));
        release_reset();

        // Speed 0 fills every slot: spawns at frames 1, 62, 123, 184
        for (int f = 1; f <= 184; f++) run_frame(11'($urandom), 4'd0, 0);
        check("all slots full", 64'(bus.active), 64'hF);
        for (int f = 185; f <= 245; f++) run_frame(11'($urandom), 4'd0, 0);
        check("full screen no spawn", 64'(frame_pulses), 64'd0);
        for (int f = 246; f <= 276; f++) run_frame(11'($urandom), 4'd15, 0);
        check("still full at y 465", 64'(bus.active), 64'hF);
        run_frame(11'($urandom), 4'd15, 0);
        check("freed then refilled", 64'(bus.active), 64'h1);
        check("refill pulse", 64'(frame_pulses), 64'd1);

        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1 bus.random = 11'($urandom);
            end
            case ($urandom_range(0, 19))
                0:       mode = 3;
                1:       mode = 1;
                2:       mode = 2;
                default: mode = 0;
            endcase
            run_frame(11'($urandom), 4'($urandom_range(0, 15)), mode);
            if (mode == 3) release_reset();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ai_traffic_scheduler.md
AI_TRAFFIC_SCHEDULER -- requirements
Module: ai_traffic_scheduler

Interface
REQ-001 Parameter NUM_CARS, default 4, number of AI car slots.
REQ-002 Parameter SCREEN_H, default 480, y at or beyond which a car leaves the screen.
REQ-003 Parameter X_MIN, default 192, leftmost spawn x.
REQ-004 Parameter X_SPAN, default 128, spawn x range width (power of two).
REQ-005 Parameter SPAWN_GAP, default 60, minimum frames between spawns.
REQ-006 clk  input  1  system clock.
REQ-007 resetN  input  1  reset, asynchronous, active-low.
REQ-008 frame_start  input  1  one-cycle pulse per video frame.
REQ-009 random  input  11  free-running pseudo-random value.
REQ-010 speed  input  4  per-frame y increment.
REQ-011 cars_state  output  NUM_CARS x 5 x 11  per slot {img_id, x, y, width, height}.
REQ-012 active  output  NUM_CARS  bit i set when slot i is on screen.
REQ-013 spawn_pulse  output  1  one-cycle pulse when a car is spawned.
REQ-014 overrun  output  1  sticky flag: frame_start arrived while busy.

Function
REQ-015 The FSM SHALL have states IDLE, MOVE, SPAWN, PUBLISH.
REQ-016 IDLE -> MOVE on frame_start; slot index cleared to 0.
REQ-017 MOVE SHALL process one slot per cycle, index 0..NUM_CARS-1, then go to SPAWN.
REQ-018 In MOVE, an active slot SHALL get y_next = y + speed, computed at 12 bits.
REQ-019 If y_next >= SCREEN_H, the slot SHALL be cleared inactive and keep its old y.
REQ-020 Inactive slots SHALL be left unchanged in MOVE.
REQ-021 SPAWN SHALL last one cycle and then go to PUBLISH.
REQ-022 In SPAWN, if cooldown == 0 and a free slot exists, the lowest-index free slot SHALL be loaded with img_id = 1 + random[10:9], x = X_MIN + (random mod X_SPAN), y = 0, width = 64, height = 64.
REQ-023 The same spawn SHALL set the slot active, reload cooldown to SPAWN_GAP, and assert spawn_pulse for that cycle.
REQ-024 If cooldown == 0 but all slots are active, there SHALL be no spawn, and cooldown SHALL stay 0.
REQ-025 Cooldown SHALL decrement by 1 once per frame, in SPAWN, when it is nonzero and no spawn occurs; it SHALL saturate at 0.
REQ-026 PUBLISH SHALL copy the working registers to cars_state and active in one cycle, then return to IDLE.
REQ-027 Outputs SHALL change only in PUBLISH, so downstream logic sees a consistent snapshot.
REQ-028 Latency from frame_start to published outputs SHALL be NUM_CARS + 3 cycles.
REQ-029 frame_start outside IDLE SHALL be ignored and SHALL set overrun; only reset clears overrun.
REQ-030 frame_start in the PUBLISH->IDLE cycle SHALL be ignored (the FSM is not yet in IDLE).
REQ-031 speed = 0 SHALL leave every y unchanged; spawning still proceeds.

Reset
REQ-032 On reset, all slots SHALL be inactive with state {1, 0, 0, 64, 64}.
REQ-033 On reset, active = 0, spawn_pulse = 0, overrun = 0, cooldown = 0, FSM = IDLE, index = 0.
REQ-034 Reset asserted mid-frame SHALL abort the sequence, with no partial publish.

Structure
REQ-035 The car-state field indices, the 5x11 car-state typedef, and the default car-state constant SHALL live in a shared package, common with the single-car controllers.
REQ-036 The free-slot priority encoder SHALL be the sub-module slot_finder, taking an active mask and returning a found flag and an index.

Verification
REQ-037 Reset then a first frame_start with random=0x005 -> after 7 cycles: slot0 active, x=197, y=0, img_id=1; spawn_pulse seen once.
REQ-038 speed=4 with slot0 at y=476 -> after the next frame slot0 is inactive and active[0]=0.
REQ-039 SPAWN_GAP=60, 59 frames after a spawn -> no spawn; the 61st frame -> a spawn into the lowest free slot.
REQ-040 All 4 slots active and cooldown 0 -> no spawn_pulse; a spawn occurs in the frame after a slot frees.
REQ-041 frame_start pulsed during MOVE -> overrun=1 and the frame count is unaffected; overrun is cleared only by resetN.
REQ-042 resetN asserted during MOVE -> all outputs equal their reset values the next cycle; normal operation resumes afterwards.
